serial_mag_compare: RTL and testbench
=====================================

SERIAL_MAG_COMPARE -- requirements
Module: serial_mag_compare

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of DIGIT and at least 2*DIGIT.
REQ-002 Parameter DIGIT, default 4, bits compared per clock cycle, MSB-first.
REQ-003 clk  input  1  single clock; all state SHALL change only on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a compare; sampled on the rising edge.
REQ-006 in1  input  WIDTH  first operand; sampled only when start is accepted.
REQ-007 in2  input  WIDTH  second operand; sampled only when start is accepted.
REQ-008 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with the operands.
REQ-009 busy  output  1  compare in progress.
REQ-010 done  output  1  one-cycle pulse: result valid.
REQ-011 low  output  1  in1 < in2.
REQ-012 equal  output  1  in1 == in2.
REQ-013 great  output  1  in1 > in2.

Function
REQ-014 Let N = WIDTH/DIGIT; the block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL capture in1, in2 and signed_mode into internal registers, clear the digit counter and go to RUN.
REQ-016 start SHALL be ignored in RUN; captured operands SHALL NOT change until the next accepted start.
REQ-017 Each RUN cycle SHALL compare one DIGIT-bit slice of the captured operands, from the most significant slice to the least significant.
REQ-018 The first unequal slice SHALL fix the result; later slices SHALL NOT alter it.
REQ-019 In signed mode, the operand MSBs SHALL be inverted before comparing the most significant slice; no other bits are affected.
REQ-020 Without the early-exit option, RUN SHALL last exactly N cycles; done SHALL rise N edges after the edge that sampled start.
REQ-021 On the transition to DONE, exactly one of low/equal/great SHALL be set; all three SHALL hold that value until the next DONE or reset.
REQ-022 done SHALL be high for exactly one cycle, in DONE; DONE SHALL return to IDLE unless start=1.
REQ-023 busy SHALL equal 1 exactly while the FSM is in RUN.
REQ-024 During RUN, low/equal/great SHALL keep the previous result.
REQ-025 All-zero, all-one and MSB-only operand patterns SHALL need no special-case latency.

Reset
REQ-026 When rst=1 at an edge, the FSM SHALL enter IDLE and busy, done, low, equal and great SHALL all be 0, with rst dominant over start.
REQ-027 rst in RUN SHALL abort the compare without a done pulse; the first start after reset SHALL behave as in REQ-015.

Configuration
REQ-028 Macro SERIAL_CMP_EARLY_EXIT_EN defined: RUN SHALL end at the first unequal slice k (1-based), with done k edges after start; equal operands SHALL still take N cycles.
REQ-029 Macro SERIAL_CMP_EARLY_EXIT_EN undefined: fixed N-cycle latency per REQ-020; flag values SHALL be identical in both builds.

Verification (WIDTH=16, DIGIT=4)
REQ-030 The bench SHALL check: unsigned 0xB000 vs 0x5FFF -> great=1; done at edge 4, or edge 1 with SERIAL_CMP_EARLY_EXIT_EN.
REQ-031 The bench SHALL check: 0x6A6A vs 0x6A6A -> equal=1, low=great=0; done at edge 4 in both builds.
REQ-032 The bench SHALL check: 0x8000 vs 0x0001 -> signed_mode=1 gives low=1; signed_mode=0 gives great=1.
REQ-033 The bench SHALL check: 0x1234 vs 0x1235 -> low=1 at edge 4 in both builds; start pulsed during RUN is ignored and the result is unchanged.
REQ-034 The bench SHALL check: rst on the 2nd RUN cycle -> next edge gives busy=done=low=equal=great=0 and no done pulse afterwards.
REQ-035 The bench SHALL check: start held high in the DONE cycle with new operands 0x0001 vs 0x0002 -> immediate re-entry to RUN, then low=1 after a further N edges.

Source files
------------

// File: rtl/serial_mag_compare_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_mag_compare_if : request/result bundle for serial_mag_compare
// Revision: 1.0
// ---------------------------------------------------------------------------
interface serial_mag_compare_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             low;
  logic             equal;
  logic             great;

  modport master (
    output start, in1, in2, signed_mode,
    input  busy, done, low, equal, great
  );

  modport slave (
    input  start, in1, in2, signed_mode,
    output busy, done, low, equal, great
  );
endinterface
`default_nettype wire

// File: rtl/serial_mag_compare.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_mag_compare : digit-serial MSB-first magnitude comparator.
// SERIAL_CMP_EARLY_EXIT_EN: stop RUN at the first unequal digit.
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_mag_compare #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_mag_compare_if.slave   bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [CNT_W-1:0] cnt;
  logic             decided, res_lt, res_gt;
  logic             low_q, equal_q, great_q;

  logic             accept, finish, step_finish;
  logic             slice_lt, slice_gt, fin_lt, fin_gt;
  logic [WIDTH-1:0] msb_flip;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign msb_flip = {bus.signed_mode, {(WIDTH-1){1'b0}}};
  assign slice_lt = sa[WIDTH-1 -: DIGIT] < sb[WIDTH-1 -: DIGIT];
  assign slice_gt = sa[WIDTH-1 -: DIGIT] > sb[WIDTH-1 -: DIGIT];
  assign fin_lt   = res_lt | (~decided & slice_lt);
  assign fin_gt   = res_gt | (~decided & slice_gt);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign step_finish = (cnt == LAST) || (~decided && (slice_lt || slice_gt));
`else
  assign step_finish = (cnt == LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (step_finish) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        accept    = bus.start;
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      res_lt  <= 1'b0;
      res_gt  <= 1'b0;
      low_q   <= 1'b0;
      equal_q <= 1'b0;
      great_q <= 1'b0;
    end else if (accept) begin
      sa      <= bus.in1 ^ msb_flip;
      sb      <= bus.in2 ^ msb_flip;
      cnt     <= '0;
      decided <= 1'b0;
      res_lt  <= 1'b0;
      res_gt  <= 1'b0;
    end else if (state == RUN) begin
      sa  <= {sa[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
      sb  <= {sb[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
      cnt <= cnt + 1'b1;
      if (~decided && (slice_lt || slice_gt)) begin
        decided <= 1'b1;
        res_lt  <= slice_lt;
        res_gt  <= slice_gt;
      end
      if (finish) begin
        low_q   <= fin_lt;
        great_q <= fin_gt;
        equal_q <= ~(fin_lt | fin_gt);
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.low   = low_q;
  assign bus.equal = equal_q;
  assign bus.great = great_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_mag_compare.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_mag_compare : directed self-checking bench, WIDTH=16, DIGIT=4.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_serial_mag_compare;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  serial_mag_compare_if #(.WIDTH(16)) bus ();

  serial_mag_compare #(.WIDTH(16), .DIGIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam int LAT_FAST = 1;
`else
  localparam int LAT_FAST = 4;
`endif

  // Returns the number of edges from the start-sampling edge to done (-1 on timeout).
  task automatic do_cmp(input logic [15:0] a, input logic [15:0] b, input logic sm,
                        output int lat);
    @(negedge clk);
    bus.in1 = a; bus.in2 = b; bus.signed_mode = sm; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.low, bus.equal, bus.great} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000",
               {bus.busy, bus.done, bus.low, bus.equal, bus.great});
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_unsigned_great;
    int lat;
    do_cmp(16'hB000, 16'h5FFF, 1'b0, lat);
    total_cnt++;
    if (lat !== LAT_FAST) $display("FAIL ugreat_latency: got %0d want %0d", lat, LAT_FAST);
    else pass_cnt++;
    total_cnt++;
    if ({bus.low, bus.equal, bus.great} !== 3'b001)
      $display("FAIL ugreat_flags: got %b want 001", {bus.low, bus.equal, bus.great});
    else pass_cnt++;
  endtask

  task automatic test_equal;
    int lat;
    do_cmp(16'h6A6A, 16'h6A6A, 1'b0, lat);
    total_cnt++;
    if (lat !== 4) $display("FAIL equal_latency: got %0d want 4", lat);
    else pass_cnt++;
    total_cnt++;
    if ({bus.low, bus.equal, bus.great} !== 3'b010)
      $display("FAIL equal_flags: got %b want 010", {bus.low, bus.equal, bus.great});
    else pass_cnt++;
  endtask

  task automatic test_signed;
    int lat;
    do_cmp(16'h8000, 16'h0001, 1'b1, lat);
    total_cnt++;
    if (lat !== LAT_FAST) $display("FAIL signed_latency: got %0d want %0d", lat, LAT_FAST);
    else pass_cnt++;
    total_cnt++;
    if ({bus.low, bus.equal, bus.great} !== 3'b100)
      $display("FAIL signed_flags: got %b want 100", {bus.low, bus.equal, bus.great});
    else pass_cnt++;
    do_cmp(16'h8000, 16'h0001, 1'b0, lat);
    total_cnt++;
    if (lat !== LAT_FAST) $display("FAIL unsigned_msb_latency: got %0d want %0d", lat, LAT_FAST);
    else pass_cnt++;
    total_cnt++;
    if ({bus.low, bus.equal, bus.great} !== 3'b001)
      $display("FAIL unsigned_msb_flags: got %b want 001", {bus.low, bus.equal, bus.great});
    else pass_cnt++;
  endtask

  task automatic test_start_in_run;
    int lat;
    @(negedge clk);
    bus.in1 = 16'h1234; bus.in2 = 16'h1235; bus.signed_mode = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL run_busy: got %b want 1", bus.busy);
    else pass_cnt++;
    total_cnt++;
    if ({bus.low, bus.equal, bus.great} !== 3'b001)
      $display("FAIL run_hold_prev: got %b want 001", {bus.low, bus.equal, bus.great});
    else pass_cnt++;
    // Competing request with opposite ordering while RUN is active.
    @(negedge clk);
    bus.in1 = 16'hFFFF; bus.in2 = 16'h0000; bus.signed_mode = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    if (bus.done) lat = 2;
    for (int k = 3; k <= 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus.done) lat = k;
    end
    total_cnt++;
    if (lat !== 4) $display("FAIL ignore_start_latency: got %0d want 4", lat);
    else pass_cnt++;
    total_cnt++;
    if ({bus.low, bus.equal, bus.great} !== 3'b100)
      $display("FAIL ignore_start_flags: got %b want 100", {bus.low, bus.equal, bus.great});
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({bus.busy, bus.done} !== 2'b00)
      $display("FAIL done_one_cycle: got busy,done=%b want 00", {bus.busy, bus.done});
    else pass_cnt++;
    total_cnt++;
    if ({bus.low, bus.equal, bus.great} !== 3'b100)
      $display("FAIL idle_hold_flags: got %b want 100", {bus.low, bus.equal, bus.great});
    else pass_cnt++;
  endtask

  task automatic test_rst_in_run;
    int lat;
    bit saw_done;
    @(negedge clk);
    bus.in1 = 16'h0000; bus.in2 = 16'hFFFF; bus.signed_mode = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.low, bus.equal, bus.great} !== 5'b0)
      $display("FAIL rst_in_run: got %b want 00000",
               {bus.busy, bus.done, bus.low, bus.equal, bus.great});
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    total_cnt++;
    if (saw_done !== 1'b0) $display("FAIL rst_no_done: got done pulse=%b want 0", saw_done);
    else pass_cnt++;
    do_cmp(16'h0003, 16'h0002, 1'b0, lat);
    total_cnt++;
    if (lat !== 4) $display("FAIL post_rst_latency: got %0d want 4", lat);
    else pass_cnt++;
    total_cnt++;
    if ({bus.low, bus.equal, bus.great} !== 3'b001)
      $display("FAIL post_rst_flags: got %b want 001", {bus.low, bus.equal, bus.great});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat;
    do_cmp(16'hFFFF, 16'h0000, 1'b0, lat);
    total_cnt++;
    if (lat !== LAT_FAST) $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT_FAST);
    else pass_cnt++;
    // Request presented during the DONE cycle itself.
    bus.in1 = 16'h0001; bus.in2 = 16'h0002; bus.signed_mode = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total_cnt++;
    if ({bus.busy, bus.done} !== 2'b10)
      $display("FAIL b2b_reenter: got busy,done=%b want 10", {bus.busy, bus.done});
    else pass_cnt++;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = k; break; end
    end
    total_cnt++;
    if (lat !== 4) $display("FAIL b2b_latency: got %0d want 4", lat);
    else pass_cnt++;
    total_cnt++;
    if ({bus.low, bus.equal, bus.great} !== 3'b100)
      $display("FAIL b2b_flags: got %b want 100", {bus.low, bus.equal, bus.great});
    else pass_cnt++;
  endtask

  initial begin
    bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.signed_mode = 1'b0;
    test_reset();
    test_unsigned_great();
    test_equal();
    test_signed();
    test_start_in_run();
    test_rst_in_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire
